// File: rtl/sqr_pkg.sv
// rtl/sqr_pkg.sv - shared state type and width constants for the sequential squarer
package sqr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sqr_state_e;

  localparam int WIDTH_DEF = 8;
  localparam int SQ_W      = 2 * WIDTH_DEF;
  localparam int REM_W     = 2 * WIDTH_DEF + 1;

  // Square width for a given root width
  function automatic int sq_w(input int w);
    return 2 * w;
  endfunction

  // Signed remainder width for a given root width (one extra sign bit)
  function automatic int rem_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/sqr_add_shift.sv
// rtl/sqr_add_shift.sv - one combinational shift-add iteration of the squarer
module sqr_add_shift
  import sqr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0]   mplier_o
);

  // Add the shifted multiplicand when the current multiplier bit is set;
  // the product of two WIDTH-bit values always fits in 2*WIDTH bits.
  assign acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
  assign mcand_o  = {mcand_i[2*WIDTH-2:0], 1'b0};
  assign mplier_o = {1'b0, mplier_i[WIDTH-1:1]};

endmodule

// File: rtl/seq_squarer.sv
// rtl/seq_squarer.sv - sequential shift-add squarer, optional remainder check under SQR_REM_CHECK_EN
module seq_squarer
  import sqr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     root_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   square_out
`ifdef SQR_REM_CHECK_EN
  ,
  input  logic [2*WIDTH-1:0]   radicand_in,
  output logic [2*WIDTH:0]     rem_out,
  output logic                 rem_ok
`endif
);

  localparam int SW = sq_w(WIDTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sqr_state_e      state_q;
  logic [SW-1:0]   acc_q, acc_d;
  logic [SW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, done_q;
  logic [SW-1:0]   square_q;

  sqr_add_shift #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_d),
    .mcand_o  (mcand_d),
    .mplier_o (mplier_d)
  );

`ifdef SQR_REM_CHECK_EN
  localparam int RW = rem_w(WIDTH);
  logic [WIDTH-1:0] root_q;
  logic [SW-1:0]    rad_q;
  logic [RW-1:0]    rem_q, rem_d;
  logic             rem_ok_q, rem_ok_d;

  // Remainder of the final square against the captured radicand; a valid sqrt
  // remainder lies in [0, 2*root]
  always_comb begin
    rem_d    = {1'b0, rad_q} - {1'b0, acc_d};
    rem_ok_d = !rem_d[RW-1] && (rem_d <= {{(RW-WIDTH-1){1'b0}}, root_q, 1'b0});
  end
`endif

  // Control FSM, datapath registers and held outputs; DONE accepts start like IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      square_q <= '0;
`ifdef SQR_REM_CHECK_EN
      root_q   <= '0;
      rad_q    <= '0;
      rem_q    <= '0;
      rem_ok_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, root_in};
            mplier_q <= root_in;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
`ifdef SQR_REM_CHECK_EN
            root_q   <= root_in;
            rad_q    <= radicand_in;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            square_q <= acc_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
`ifdef SQR_REM_CHECK_EN
            rem_q    <= rem_d;
            rem_ok_q <= rem_ok_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign square_out = square_q;
`ifdef SQR_REM_CHECK_EN
  assign rem_out    = rem_q;
  assign rem_ok     = rem_ok_q;
`endif

endmodule

// File: tb/tb_seq_squarer.sv
// tb/tb_seq_squarer.sv - randomized and directed bench for seq_squarer against a timing-level model
module tb_seq_squarer;

  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [W-1:0]     root_in = '0;
  logic             busy, done;
  logic [2*W-1:0]   square_out;
`ifdef SQR_REM_CHECK_EN
  logic [2*W-1:0]   radicand_in = '0;
  logic [2*W:0]     rem_out;
  logic             rem_ok;
`endif

  seq_squarer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .root_in    (root_in),
    .busy       (busy),
    .done       (done),
    .square_out (square_out)
`ifdef SQR_REM_CHECK_EN
    ,
    .radicand_in(radicand_in),
    .rem_out    (rem_out),
    .rem_ok     (rem_ok)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  // Model: an accepted start schedules a result W edges later; no state encoding.
  bit  m_busy = 0;
  bit  m_done = 0;
  int  m_done_cyc = 0;
  int  m_pend = 0;
  int  m_sq = 0;
  int  m_root = 0;
  int  m_rad = 0;
  int  m_rem = 0;
  bit  m_ok = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      m_done = 0;
      if (m_busy && cyc == m_done_cyc) begin
        m_sq   = m_pend;
        m_rem  = m_rad - m_pend;
        m_ok   = (m_rem >= 0) && (m_rem <= 2 * m_root);
        m_done = 1;
        m_busy = 0;
      end else if (!m_busy && start) begin
        m_busy     = 1;
        m_done_cyc = cyc + W;
        m_pend     = int'(root_in) * int'(root_in);
        m_root     = int'(root_in);
`ifdef SQR_REM_CHECK_EN
        m_rad      = int'(radicand_in);
`endif
      end
    end
  end

  always @(negedge rst_n) begin
    m_busy = 0; m_done = 0; m_sq = 0; m_rem = 0; m_ok = 0;
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("square_out", 64'(square_out), 64'(m_sq));
`ifdef SQR_REM_CHECK_EN
    chk("rem_out", 64'(rem_out), 64'((2*W+1)'(m_rem)));
    chk("rem_ok", 64'(rem_ok), 64'(m_ok));
`endif
  end

  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    checks++;
    if (!done) begin
      errs++;
      $display("FAIL wait_done timeout at cycle %0d: got done=0 expected done=1", cyc);
    end
  endtask

  task automatic do_op(input logic [W-1:0] r, input int rad);
    int n;
    @(posedge clk); #1;
    start = 1'b1;
    root_in = r;
`ifdef SQR_REM_CHECK_EN
    radicand_in = (2*W)'(rad);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
  endtask

  task automatic count_dones(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int n, busy_cnt, t1, t2, dcnt, r, rad;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_square", 64'(square_out), 64'd0);
    rst_n = 1'b1;

    // root 0: busy exactly W cycles, done W cycles after accept
    @(posedge clk); #1; start = 1'b1; root_in = 8'd0;
    @(posedge clk); #1; start = 1'b0;
    busy_cnt = 0; n = 0;
    while (n < 40) begin
      @(negedge clk); n++;
      if (done) break;
      if (busy) busy_cnt++;
    end
    chk("zero_busy_cycles", 64'(busy_cnt), 64'd8);
    chk("zero_latency", 64'(n), 64'd9);
    chk("zero_square", 64'(square_out), 64'd0);

    // 255 then 1, old value held through the second run
    do_op(8'd255, 0);
    chk("sq_255", 64'(square_out), 64'd65025);
    @(posedge clk); #1; start = 1'b1; root_in = 8'd1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_during_run", 64'(square_out), 64'd65025);
    wait_done(n);
    chk("sq_1", 64'(square_out), 64'd1);

    // start held high: 12 then 13 presented in the DONE cycle
    @(posedge clk); #1; start = 1'b1; root_in = 8'd12;
    wait_done(n);
    t1 = cyc;
    chk("sq_12", 64'(square_out), 64'd144);
    root_in = 8'd13;
    wait_done(n);
    t2 = cyc;
    start = 1'b0;
    chk("sq_13", 64'(square_out), 64'd169);
    chk("b2b_spacing", 64'(t2 - t1), 64'd9);

    // start re-pulsed during RUN is ignored
    @(posedge clk); #1; start = 1'b1; root_in = 8'd10;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; start = 1'b1; root_in = 8'd3;
    @(posedge clk); #1; start = 1'b0;
    wait_done(n);
    chk("sq_10_ignore", 64'(square_out), 64'd100);
    count_dones(14, dcnt);
    chk("no_extra_done", 64'(dcnt), 64'd0);

    // Reset mid-RUN aborts with no done
    @(posedge clk); #1; start = 1'b1; root_in = 8'd99;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_square", 64'(square_out), 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    count_dones(14, dcnt);
    chk("abort_no_done", 64'(dcnt), 64'd0);
    do_op(8'd7, 49);
    chk("sq_7", 64'(square_out), 64'd49);

`ifdef SQR_REM_CHECK_EN
    do_op(8'd14, 200);
    chk("rem_14_200", 64'(rem_out), 64'(17'd4));
    chk("ok_14_200", 64'(rem_ok), 64'd1);
    do_op(8'd15, 200);
    chk("rem_15_200", 64'(rem_out), 64'(17'h1FFE7));
    chk("ok_15_200", 64'(rem_ok), 64'd0);
    do_op(8'd14, 224);
    chk("rem_14_224", 64'(rem_out), 64'(17'd28));
    chk("ok_14_224", 64'(rem_ok), 64'd1);
    do_op(8'd14, 225);
    chk("rem_14_225", 64'(rem_out), 64'(17'd29));
    chk("ok_14_225", 64'(rem_ok), 64'd0);
`endif

    // Random start/root/radicand traffic, checked by the every-cycle compare
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 255);
      root_in = W'(r);
      rad = r * r + $urandom_range(0, 2 * r + 3) - 1;
      if (rad < 0) rad = 0;
`ifdef SQR_REM_CHECK_EN
      radicand_in = (2*W)'(rad);
`endif
    end
    @(posedge clk); #1; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
